clk_en_divider_bank: RTL and testbench

Multi-channel clock-enable generator with programmable divide ratio and phase per channel. It replaces fabric clock dividers and buffered derived clocks with single-clock enable strobes, so all logic stays in one clock domain for constraint and timing purposes. Each channel drives a free-running event counter and a lock flag. Reconfiguration takes effect at the channel's wrap boundary, so strobe spacing never glitches.

---
 rtl/clk_en_pkg.sv | 28 ++
 rtl/clk_en_channel.sv | 83 ++++++++
 rtl/clk_en_divider_bank.sv | 59 +++++
 tb/tb_clk_en_divider_bank.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_en_pkg.sv
// rtl/clk_en_pkg.sv - shared state, config types and default widths for the clock-enable divider bank
package clk_en_pkg;

  localparam int NUM_CH_DEF     = 4;
  localparam int DIV_WIDTH_DEF  = 4;
  localparam int CNT_WIDTH_DEF  = 8;
  localparam int LOCK_WRAPS_DEF = 2;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    PEND     = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [DIV_WIDTH_DEF-1:0] div;
    logic [DIV_WIDTH_DEF-1:0] phase;
  } ch_cfg_t;

  // A phase at or beyond the period would never match pc, so pin it to the last slot.
  function automatic ch_cfg_t clamp_cfg(input ch_cfg_t c);
    ch_cfg_t r;
    r = c;
    if (c.div != '0 && c.phase >= c.div) r.phase = c.div - DIV_WIDTH_DEF'(1);
    return r;
  endfunction

endpackage

// File: rtl/clk_en_channel.sv
// rtl/clk_en_channel.sv - one divider channel: FSM, phase counter, event counter, lock and pending slot
module clk_en_channel
  import clk_en_pkg::*;
#(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int LOCK_WRAPS = LOCK_WRAPS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_sel,
  input  ch_cfg_t              cfg,
  output logic                 pend,
  output logic                 ce,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 locked
);

  localparam int LW = (LOCK_WRAPS > 1) ? $clog2(LOCK_WRAPS) : 1;

  ch_state_e            state_q, state_d;
  ch_cfg_t              cur_q, pend_q;
  logic [DIV_WIDTH-1:0] pc_q;
  logic [LW-1:0]        lock_cnt_q;
  logic                 accept, wrap, hit, load;

  assign pend   = (state_q == PEND);
  assign accept = cfg_sel && (state_q != PEND);
  assign wrap   = (state_q != DISABLED) && (pc_q == cur_q.div - DIV_WIDTH'(1));
  assign hit    = (state_q != DISABLED) && (pc_q == cur_q.phase);
  assign load   = wrap && (state_q == PEND);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISABLED: if (accept && cfg.div != '0) state_d = RUN;
      RUN:      if (accept) state_d = PEND;
      PEND:     if (wrap) state_d = (pend_q.div != '0) ? RUN : DISABLED;
      default:  state_d = DISABLED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DISABLED;
      cur_q      <= '0;
      pend_q     <= '0;
      pc_q       <= '0;
      lock_cnt_q <= '0;
      ce         <= 1'b0;
      cnt        <= '0;
      locked     <= 1'b0;
    end else begin
      state_q <= state_d;
      ce      <= hit;
      if (hit) cnt <= cnt + CNT_WIDTH'(1);

      // A config only ever reaches cur_q at a period boundary, which keeps strobe spacing clean.
      if (state_q == DISABLED && accept) begin
        cur_q <= clamp_cfg(cfg);
        pc_q  <= '0;
      end else if (load) begin
        cur_q <= clamp_cfg(pend_q);
        pc_q  <= '0;
      end else if (state_q != DISABLED) begin
        pc_q <= wrap ? '0 : pc_q + DIV_WIDTH'(1);
      end

      if (state_q == RUN && accept) pend_q <= cfg;
      else if (load)                pend_q <= '0;

      // Wraps are only counted in RUN, so a lock always reflects the config actually loaded.
      if (accept) begin
        lock_cnt_q <= '0;
        locked     <= 1'b0;
      end else if (state_q == RUN && wrap && !locked) begin
        if (lock_cnt_q == LW'(LOCK_WRAPS - 1)) locked <= 1'b1;
        else lock_cnt_q <= lock_cnt_q + LW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_en_divider_bank.sv
// rtl/clk_en_divider_bank.sv - bank of programmable clock-enable dividers sharing one config port
module clk_en_divider_bank
  import clk_en_pkg::*;
#(
  parameter int NUM_CH     = NUM_CH_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int LOCK_WRAPS = LOCK_WRAPS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(NUM_CH):0]       cfg_ch,
  input  logic [DIV_WIDTH-1:0]          cfg_div,
  input  logic [DIV_WIDTH-1:0]          cfg_phase,
  output logic [NUM_CH-1:0]             ce,
  output logic [NUM_CH-1:0]             out,
  output logic [NUM_CH*CNT_WIDTH-1:0]   cnt,
  output logic [NUM_CH-1:0]             locked
);

  localparam int CH_W = $clog2(NUM_CH) + 1;

  ch_cfg_t           cfg_in;
  logic [NUM_CH-1:0] pend_vec;

  assign cfg_in = '{div: cfg_div, phase: cfg_phase};

  // Out-of-range channel numbers match nothing, so they are always ready and silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      if (cfg_ch == CH_W'(i) && pend_vec[i]) cfg_ready = 1'b0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] ch_cnt;

    clk_en_channel #(
      .DIV_WIDTH (DIV_WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .LOCK_WRAPS(LOCK_WRAPS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .cfg_sel(cfg_valid && (cfg_ch == CH_W'(i))),
      .cfg    (cfg_in),
      .pend   (pend_vec[i]),
      .ce     (ce[i]),
      .cnt    (ch_cnt),
      .locked (locked[i])
    );

    assign cnt[i*CNT_WIDTH +: CNT_WIDTH] = ch_cnt;
    assign out[i]                        = ch_cnt[0];
  end

endmodule

// File: tb/tb_clk_en_divider_bank.sv
// tb/tb_clk_en_divider_bank.sv - directed and randomized bench for clk_en_divider_bank with a time-based model
module tb_clk_en_divider_bank;

  localparam int NUM_CH     = 4;
  localparam int DIV_WIDTH  = 4;
  localparam int CNT_WIDTH  = 8;
  localparam int LOCK_WRAPS = 2;
  localparam int CH_W       = $clog2(NUM_CH) + 1;
  localparam int CNT_MOD    = 1 << CNT_WIDTH;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        cfg_valid = 1'b0;
  logic                        cfg_ready;
  logic [CH_W-1:0]             cfg_ch = '0;
  logic [DIV_WIDTH-1:0]        cfg_div = '0;
  logic [DIV_WIDTH-1:0]        cfg_phase = '0;
  logic [NUM_CH-1:0]           ce, out, locked;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt;

  always #5 clk = ~clk;

  clk_en_divider_bank #(
    .NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH), .CNT_WIDTH(CNT_WIDTH), .LOCK_WRAPS(LOCK_WRAPS)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .ce(ce), .out(out), .cnt(cnt), .locked(locked)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: a running channel is described by its period start time t0, not by a phase counter.
  bit m_on[NUM_CH];
  int m_d[NUM_CH], m_p[NUM_CH], m_t0[NUM_CH];
  bit m_pend[NUM_CH];
  int m_pd[NUM_CH], m_pp[NUM_CH];
  bit m_lock_ok[NUM_CH];
  int m_cnt[NUM_CH];
  bit m_ce[NUM_CH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int clampp(input int d, input int p);
    return (p >= d) ? d - 1 : p;
  endfunction

  task automatic model_step(input bit r, input bit v, input int ch, input int d, input int p);
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit, wrap, acc;
      int pos;
      if (r) begin
        m_on[c] = 0; m_d[c] = 0; m_p[c] = 0; m_t0[c] = 0; m_pend[c] = 0;
        m_pd[c] = 0; m_pp[c] = 0; m_lock_ok[c] = 0; m_cnt[c] = 0; m_ce[c] = 0;
        continue;
      end
      pos  = m_on[c] ? (cyc - m_t0[c]) % m_d[c] : -1;
      hit  = m_on[c] && pos == m_p[c];
      wrap = m_on[c] && pos == m_d[c] - 1;
      acc  = v && ch == c && !m_pend[c];
      m_ce[c] = hit;
      if (hit) m_cnt[c] = (m_cnt[c] + 1) % CNT_MOD;
      if (m_pend[c] && wrap) begin
        m_pend[c] = 0;
        m_lock_ok[c] = 1;
        if (m_pd[c] == 0) m_on[c] = 0;
        else begin
          m_on[c] = 1; m_d[c] = m_pd[c]; m_p[c] = clampp(m_pd[c], m_pp[c]); m_t0[c] = cyc + 1;
        end
      end else if (acc && !m_on[c]) begin
        if (d != 0) begin
          m_on[c] = 1; m_d[c] = d; m_p[c] = clampp(d, p); m_t0[c] = cyc + 1; m_lock_ok[c] = 1;
        end
      end else if (acc) begin
        m_pend[c] = 1; m_pd[c] = d; m_pp[c] = p; m_lock_ok[c] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0]           e_ce, e_out, e_lk;
    logic [NUM_CH*CNT_WIDTH-1:0] e_cnt;
    for (int c = 0; c < NUM_CH; c++) begin
      e_ce[c]  = m_ce[c];
      e_out[c] = m_cnt[c][0];
      e_lk[c]  = m_on[c] && m_lock_ok[c] && (cyc - m_t0[c]) >= LOCK_WRAPS * m_d[c];
      e_cnt[c*CNT_WIDTH +: CNT_WIDTH] = CNT_WIDTH'(m_cnt[c]);
    end
    check_eq("ce", ce, e_ce);
    check_eq("cnt", cnt, e_cnt);
    check_eq("out", out, e_out);
    check_eq("locked", locked, e_lk);
  endtask

  task automatic tick(input bit v, input int ch, input int d, input int p);
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_WIDTH'(d);
    cfg_phase = DIV_WIDTH'(p);
    #1;
    if (!rst) check_eq("cfg_ready", cfg_ready, (ch >= NUM_CH) ? 1'b1 : !m_pend[ch]);
    @(posedge clk);
    model_step(rst, v, ch, d, p);
    cyc++;
    #1;
    check_outputs();
  endtask

  task automatic reset_bank(input int hold_ch);
    rst = 1'b1;
    repeat (3) tick(0, hold_ch, 0, 0);
    rst = 1'b0;
    cyc = 0;
    check_eq("rst_ce", ce, 0);
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_out", out, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_ready", cfg_ready, 1);
  endtask

  initial begin
    int   ce0_q[$];
    int   ce3_q[$];
    int   lk0_first;
    int   low_cnt;
    int   w;
    logic [CNT_WIDTH-1:0] c_hold;
    bit   ce_seen;

    reset_bank(0);

    while (cyc < 10) tick(0, 0, 0, 0);
    lk0_first = -1;
    tick(1, 0, 4, 1);
    while (cyc <= 22) begin
      if (ce[0]) ce0_q.push_back(cyc);
      if (locked[0] && lk0_first < 0) lk0_first = cyc;
      if (cyc == 22) check_eq("cnt0_at_22", cnt[7:0], 3);
      tick(0, 0, 0, 0);
    end
    check_eq("ce0_count", ce0_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("ce0_time%0d", i), (i < ce0_q.size()) ? ce0_q[i] : -1, 13 + 4 * i);
    check_eq("lock0_first", lk0_first, 19);

    tick(1, 1, 5, 2);
    for (int k = 0; k < 10 && ((cyc - m_t0[1]) % 5) != 2; k++) tick(0, 1, 0, 0);
    check_eq("ch1_align", (cyc - m_t0[1]) % 5, 2);
    tick(1, 1, 3, 0);
    low_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (!cfg_ready) low_cnt++;
      tick(0, 1, 0, 0);
    end
    check_eq("ch1_ready_low_cycles", low_cnt, 2);

    tick(1, 2, 1, 7);
    tick(0, 2, 0, 0);
    check_eq("ce2_first", ce[2], 1);
    c_hold = cnt[23:16];
    repeat (256) tick(0, 2, 0, 0);
    check_eq("cnt2_wrap_256", cnt[23:16], c_hold);
    check_eq("ce2_steady", ce[2], 1);

    tick(1, 3, 3, 1);
    for (int k = 0; k < 10 && ((cyc - m_t0[3]) % 3) != 2; k++) tick(0, 3, 0, 0);
    check_eq("ch3_align", (cyc - m_t0[3]) % 3, 2);
    w = cyc;
    tick(1, 3, 2, 0);
    while (cyc <= w + 8) begin
      if (ce[3]) ce3_q.push_back(cyc - w);
      tick(0, 3, 0, 0);
    end
    check_eq("ce3_count", ce3_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("ce3_offset%0d", i), (i < ce3_q.size()) ? ce3_q[i] : -1, 3 + 2 * i);
    tick(1, NUM_CH, 5, 5);
    tick(0, NUM_CH, 0, 0);

    tick(1, 0, 0, 0);
    repeat (6) tick(0, 0, 0, 0);
    c_hold  = cnt[7:0];
    ce_seen = 0;
    repeat (10) begin
      tick(0, 0, 0, 0);
      ce_seen |= ce[0];
    end
    check_eq("ce0_stopped", ce_seen, 0);
    check_eq("cnt0_hold", cnt[7:0], c_hold);
    check_eq("locked0_off", locked[0], 0);

    repeat (800) begin
      if ($urandom_range(0, 3) == 0)
        tick(1, $urandom_range(0, NUM_CH), ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15),
             $urandom_range(0, 15));
      else
        tick(0, $urandom_range(0, NUM_CH), 0, 0);
    end

    for (int k = 0; k < 20 && m_pend[1]; k++) tick(0, 1, 0, 0);
    tick(1, 1, 15, 3);
    tick(1, 1, 14, 2);
    reset_bank(1);
    tick(0, 1, 0, 0);

    repeat (300) begin
      if ($urandom_range(0, 2) == 0)
        tick(1, $urandom_range(0, NUM_CH), $urandom_range(0, 15), $urandom_range(0, 15));
      else
        tick(0, $urandom_range(0, NUM_CH), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
